// File: rtl/i2s_rx_if.sv
// Parallel sample port of the I2S receiver: stereo word pair with a
// valid/ready handshake plus the two 1-clk status pulses.
interface i2s_rx_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] out_left;
    logic [DATA_WIDTH-1:0] out_right;
    logic                  out_valid;
    logic                  out_ready;
    logic                  overrun;
    logic                  frame_err;

    // Receiver side: produces samples and status.
    modport master (
        output out_left,
        output out_right,
        output out_valid,
        output overrun,
        output frame_err,
        input  out_ready
    );

    // Consumer side: takes samples and acknowledges them.
    modport slave (
        input  out_left,
        input  out_right,
        input  out_valid,
        input  overrun,
        input  frame_err,
        output out_ready
    );
endinterface

// File: rtl/i2s_rx.sv
// I2S receive deserializer. bclk/adclrck/adcdat arrive asynchronously from
// the codec and are resynchronised into clk. A small FSM frames the serial
// stream into left/right words, which are presented as a pair on rx_if.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_ALIGN | after reset; wait for the first LR fall (start of a left slot)
// ST_DELAY | LR edge seen; skip the one-bit I2S delay slot
// ST_SHIFT | shifting DATA_WIDTH bits MSB first into shreg
// ST_PAD   | word complete; ignore extra slot bits until the next LR edge
module i2s_rx #(
    parameter int DATA_WIDTH  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      daclrck_,
    input  logic      bclk,
    input  logic      adclrck,
    input  logic      adcdat,
    i2s_rx_if.master  rx_if
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_ALIGN,
        ST_DELAY,
        ST_SHIFT,
        ST_PAD
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers. All three pins get the same depth so the data
    // bit seen on a detected bclk rise is the one present at the pin edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] lrck_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   bclk_dly_q;
    logic                   lrck_dly_q;

    logic bclk_s;
    logic lrck_s;
    logic dat_s;
    logic bclk_rise;
    logic lr_fall;
    logic lr_rise;

    // Shift each pin through its synchroniser; keep one extra flop for edges.
    always_ff @(posedge clk or negedge daclrck_) begin
        if (!daclrck_) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            dat_sync_q  <= '0;
            bclk_dly_q  <= 1'b0;
            lrck_dly_q  <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], adclrck};
            dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], adcdat};
            bclk_dly_q  <= bclk_s;
            lrck_dly_q  <= lrck_s;
        end
    end

    assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
    assign dat_s     = dat_sync_q[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_dly_q;
    assign lr_fall   = ~lrck_s & lrck_dly_q;
    assign lr_rise   = lrck_s & ~lrck_dly_q;

    // ------------------------------------------------------------------
    // Framing FSM and datapath registers
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic                  ch_q, ch_d;          // 0 = left slot, 1 = right slot
    logic [CW-1:0]         bitcnt_q, bitcnt_d;
    logic                  left_ok_q, left_ok_d; // full left word captured this frame
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] hold_left_q;
    logic [DATA_WIDTH-1:0] shreg_shift;
    logic                  shift_en;
    logic                  load_left;
    logic                  pair_done_q, pair_done_d;
    logic                  frame_err_q, frame_err_d;

    assign shreg_shift = {shreg_q[DATA_WIDTH-2:0], dat_s};

    // FSM state, counters and the shift/hold registers.
    always_ff @(posedge clk or negedge daclrck_) begin
        if (!daclrck_) begin
            state_q     <= ST_ALIGN;
            ch_q        <= 1'b0;
            bitcnt_q    <= '0;
            left_ok_q   <= 1'b0;
            shreg_q     <= '0;
            hold_left_q <= '0;
            pair_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            bitcnt_q    <= bitcnt_d;
            left_ok_q   <= left_ok_d;
            pair_done_q <= pair_done_d;
            frame_err_q <= frame_err_d;
            if (shift_en) begin
                shreg_q <= shreg_shift;
            end
            if (load_left) begin
                hold_left_q <= shreg_shift;
            end
        end
    end

    // Next-state logic. An LR edge outranks a bclk rise in the same cycle,
    // so the delay slot always skips the next distinct bclk rise.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        bitcnt_d    = bitcnt_q;
        left_ok_d   = left_ok_q;
        shift_en    = 1'b0;
        load_left   = 1'b0;
        pair_done_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_ALIGN: begin
                if (lr_fall) begin
                    state_d   = ST_DELAY;
                    ch_d      = 1'b0;
                    bitcnt_d  = '0;
                    left_ok_d = 1'b0;
                end
            end
            default: begin
                if (lr_fall || lr_rise) begin
                    // Edge before the word finished: the partial word is lost.
                    frame_err_d = (state_q == ST_DELAY) || (state_q == ST_SHIFT);
                    state_d     = ST_DELAY;
                    ch_d        = lr_rise;
                    bitcnt_d    = '0;
                    if (lr_fall) begin
                        left_ok_d = 1'b0;
                    end
                end else if (bclk_rise) begin
                    case (state_q)
                        ST_DELAY: begin
                            state_d  = ST_SHIFT;
                            bitcnt_d = '0;
                        end
                        ST_SHIFT: begin
                            shift_en = 1'b1;
                            if (bitcnt_q != CNT_FULL) begin
                                bitcnt_d = bitcnt_q + CW'(1);
                            end
                            if (bitcnt_q == CNT_LAST) begin
                                state_d = ST_PAD;
                                if (!ch_q) begin
                                    load_left = 1'b1;
                                    left_ok_d = 1'b1;
                                end else begin
                                    // Right word only forms a pair behind a full left word.
                                    pair_done_d = left_ok_q;
                                    left_ok_d   = 1'b0;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output pair register and handshake
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] out_left_q;
    logic [DATA_WIDTH-1:0] out_right_q;
    logic                  out_valid_q;
    logic                  overrun_q;

    // Load a completed pair when the slot is free (or freed this cycle);
    // otherwise drop it and flag the overrun.
    always_ff @(posedge clk or negedge daclrck_) begin
        if (!daclrck_) begin
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (pair_done_q) begin
                if (!out_valid_q || rx_if.out_ready) begin
                    out_left_q  <= hold_left_q;
                    out_right_q <= shreg_q;
                    out_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (out_valid_q && rx_if.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.out_left  = out_left_q;
    assign rx_if.out_right = out_right_q;
    assign rx_if.out_valid = out_valid_q;
    assign rx_if.overrun   = overrun_q;
    assign rx_if.frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: a table of whole stereo frames with expected
// pair/handshake outcomes, plus hand sequences for reset, latency, short
// slots and mid-frame start.
module tb_i2s_rx;
    localparam int DW   = 24;
    localparam int HALF = 5;   // clk cycles per bclk half period (10x ratio)

    logic clk      = 1'b0;
    logic daclrck_ = 1'b0;
    logic bclk     = 1'b0;
    logic adclrck  = 1'b0;
    logic adcdat   = 1'b0;

    i2s_rx_if #(.DATA_WIDTH(DW)) rif ();

    i2s_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .daclrck_ (daclrck_),
        .bclk     (bclk),
        .adclrck  (adclrck),
        .adcdat   (adcdat),
        .rx_if    (rif)
    );

    always #10 clk = ~clk;

    int   checks    = 0;
    int   failures  = 0;
    int   ovr_cnt   = 0;
    int   ferr_cnt  = 0;
    int   vrise_cnt = 0;
    logic vprev     = 1'b0;

    // Pulse/event counters, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (rif.overrun === 1'b1)                     ovr_cnt   <= ovr_cnt + 1;
        if (rif.frame_err === 1'b1)                   ferr_cnt  <= ferr_cnt + 1;
        if (rif.out_valid === 1'b1 && vprev !== 1'b1) vrise_cnt <= vrise_cnt + 1;
        vprev <= rif.out_valid;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One bclk period: fall (drive LR and data), then rise.
    task automatic bclk_cycle(input logic lr, input logic d);
        @(negedge clk);
        bclk    = 1'b0;
        adclrck = lr;
        adcdat  = d;
        repeat (HALF) @(negedge clk);
        bclk = 1'b1;
        repeat (HALF - 1) @(negedge clk);
    endtask

    // Slot: delay bit, ndata bits MSB first, then filler up to total periods.
    task automatic send_slot(input logic lr, input logic [DW-1:0] data,
                             input int total, input int ndata);
        for (int i = 0; i < total; i++) begin
            logic d;
            if (i >= 1 && i <= ndata) d = data[DW-i];
            else                      d = i[0];
            bclk_cycle(lr, d);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int slot);
        send_slot(1'b0, l, slot, DW);
        send_slot(1'b1, r, slot, DW);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk);
        rif.out_ready = 1'b1;
        @(negedge clk);
        rif.out_ready = 1'b0;
        chk("ack_clears_valid", 32'(rif.out_valid), 32'd0);
    endtask

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            slot;
        logic          ready;
        logic          do_ack;
        logic          exp_valid;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_r;
        int            exp_ovr;
        int            exp_vrise;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int o0, f0, v0, bad;
        logic [31:0] rnd;
        logic [DW-1:0] rlat;

        vecs[0] = '{24'hA5A5A5, 24'h3C0FF1, 27, 1'b0, 1'b1, 1'b1, 24'hA5A5A5, 24'h3C0FF1, 0, 1};
        vecs[1] = '{24'h111111, 24'h222222, 27, 1'b0, 1'b0, 1'b1, 24'h111111, 24'h222222, 0, 1};
        vecs[2] = '{24'h333333, 24'h444444, 27, 1'b0, 1'b0, 1'b1, 24'h111111, 24'h222222, 1, 0};
        vecs[3] = '{24'h555555, 24'h666666, 27, 1'b0, 1'b1, 1'b1, 24'h111111, 24'h222222, 1, 0};
        vecs[4] = '{24'hC00003, 24'h3FFFFC, 32, 1'b1, 1'b0, 1'b0, 24'hC00003, 24'h3FFFFC, 0, 1};
        vecs[5] = '{24'hFFFFFF, 24'h000000, 25, 1'b0, 1'b1, 1'b1, 24'hFFFFFF, 24'h000000, 0, 1};
        vecs[6] = '{24'h800001, 24'h7FFFFE, 27, 1'b0, 1'b1, 1'b1, 24'h800001, 24'h7FFFFE, 0, 1};

        rif.out_ready = 1'b0;

        // Reset held while every input toggles.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rnd = $urandom;
            bclk          = rnd[0];
            adclrck       = rnd[1];
            adcdat        = rnd[2];
            rif.out_ready = rnd[3];
            if (rif.out_valid !== 1'b0 || rif.overrun !== 1'b0 || rif.frame_err !== 1'b0 ||
                rif.out_left !== '0 || rif.out_right !== '0)
                bad++;
        end
        chk("reset_outputs_zero", 32'(bad), 32'd0);
        chk("reset_no_pulses", 32'(ovr_cnt + ferr_cnt + vrise_cnt), 32'd0);

        @(negedge clk);
        rif.out_ready = 1'b0;
        bclk    = 1'b1;
        adclrck = 1'b1;
        adcdat  = 1'b0;
        idle(2);
        daclrck_ = 1'b1;
        repeat (3) bclk_cycle(1'b1, 1'b0);

        // Table of whole frames.
        for (int i = 0; i < 7; i++) begin
            o0 = ovr_cnt; f0 = ferr_cnt; v0 = vrise_cnt;
            rif.out_ready = vecs[i].ready;
            send_frame(vecs[i].l, vecs[i].r, vecs[i].slot);
            idle(8);
            chk($sformatf("v%0d_valid", i), 32'(rif.out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_left", i), 32'(rif.out_left), 32'(vecs[i].exp_l));
            chk($sformatf("v%0d_right", i), 32'(rif.out_right), 32'(vecs[i].exp_r));
            chk($sformatf("v%0d_overrun", i), 32'(ovr_cnt - o0), 32'(vecs[i].exp_ovr));
            chk($sformatf("v%0d_frame_err", i), 32'(ferr_cnt - f0), 32'd0);
            chk($sformatf("v%0d_valid_rises", i), 32'(vrise_cnt - v0), 32'(vecs[i].exp_vrise));
            rif.out_ready = 1'b0;
            if (vecs[i].do_ack) ack();
        end

        // Latency from pin-level bclk rise of the right LSB to out_valid.
        rlat = 24'h2468AD;
        send_slot(1'b0, 24'h13579B, 27, DW);
        for (int i = 0; i < DW; i++) bclk_cycle(1'b1, (i == 0) ? 1'b1 : rlat[DW-i]);
        @(negedge clk);
        bclk   = 1'b0;
        adcdat = rlat[0];
        repeat (HALF) @(negedge clk);
        bclk = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("latency_not_before_4", 32'(rif.out_valid), 32'd0);
        @(posedge clk);
        #1 chk("latency_at_4", 32'(rif.out_valid), 32'd1);
        repeat (HALF - 1) @(negedge clk);
        repeat (2) bclk_cycle(1'b1, 1'b0);
        idle(4);
        chk("lat_left", 32'(rif.out_left), 32'h13579B);
        chk("lat_right", 32'(rif.out_right), 32'(rlat));
        ack();

        // Left slot cut at 20 bits by an early LR rise.
        o0 = ovr_cnt; f0 = ferr_cnt; v0 = vrise_cnt;
        send_slot(1'b0, 24'hFFFFFF, 21, 20);
        send_slot(1'b1, 24'h123456, 27, DW);
        idle(8);
        chk("short_frame_err", 32'(ferr_cnt - f0), 32'd1);
        chk("short_no_valid", 32'(vrise_cnt - v0), 32'd0);
        send_frame(24'h000001, 24'h800000, 27);
        idle(8);
        chk("after_short_valid", 32'(rif.out_valid), 32'd1);
        chk("after_short_left", 32'(rif.out_left), 32'h000001);
        chk("after_short_right", 32'(rif.out_right), 32'h800000);
        chk("after_short_ferr", 32'(ferr_cnt - f0), 32'd1);
        ack();

        // Reset mid-shift while a pair is held.
        send_frame(24'h0ABCDE, 24'h0FEDCB, 27);
        idle(8);
        chk("pre_reset_valid", 32'(rif.out_valid), 32'd1);
        send_slot(1'b0, 24'h555555, 11, 10);
        @(posedge clk);
        #3 daclrck_ = 1'b0;
        #1;
        chk("async_reset_valid", 32'(rif.out_valid), 32'd0);
        chk("async_reset_data", 32'(rif.out_left | rif.out_right), 32'd0);
        idle(4);
        daclrck_ = 1'b1;
        repeat (3) bclk_cycle(1'b1, 1'b0);
        o0 = ovr_cnt; f0 = ferr_cnt; v0 = vrise_cnt;
        send_frame(24'h654321, 24'hFEDCBA, 27);
        idle(8);
        chk("realign_valid", 32'(rif.out_valid), 32'd1);
        chk("realign_left", 32'(rif.out_left), 32'h654321);
        chk("realign_right", 32'(rif.out_right), 32'hFEDCBA);
        ack();

        // Reset released in the middle of a right slot.
        @(negedge clk);
        daclrck_ = 1'b0;
        adclrck  = 1'b1;
        idle(4);
        daclrck_ = 1'b1;
        o0 = ovr_cnt; f0 = ferr_cnt; v0 = vrise_cnt;
        for (int i = 0; i < 12; i++) bclk_cycle(1'b1, i[1]);
        send_frame(24'hABCDEF, 24'h123456, 27);
        idle(8);
        chk("midstart_valid", 32'(rif.out_valid), 32'd1);
        chk("midstart_left", 32'(rif.out_left), 32'hABCDEF);
        chk("midstart_right", 32'(rif.out_right), 32'h123456);
        chk("midstart_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("midstart_one_valid", 32'(vrise_cnt - v0), 32'd1);
        ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
